// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg -- shared definitions for the configuration loader.
//
// Contents:
//   state_t   : loader FSM state encoding. CRC_BYTE exists only when the
//               optional CRC check is built in.
//   CRC_POLY  : CRC-8 generator polynomial (x^8 + x^2 + x + 1, 0x07).
//   CRC_INIT  : CRC-8 register value at the start of every load.
//   crc8_step : one MSB-first bit update of the CRC-8 register.
//
// Build option: define CFG_CRC_EN to include the CRC_BYTE state.
// ---------------------------------------------------------------------------
package cfg_pkg;

`ifdef CFG_CRC_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    SHIFT     = 3'd2,
    CRC_BYTE  = 3'd3,
    DONE      = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    SHIFT     = 3'd2,
    DONE      = 3'd4
  } state_t;
`endif

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  // Feedback is the outgoing MSB xor the incoming bit; when set, the
  // polynomial is folded into the shifted register.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// ---------------------------------------------------------------------------
// crc8_serial -- bit-serial CRC-8 accumulator (poly 0x07, MSB-first).
//
// Ports:
//   clk    : clock, register updates on the rising edge
//   clear  : reload the register with CRC_INIT (takes priority over en)
//   en     : fold bit_in into the CRC this cycle
//   bit_in : serial data bit
//   crc    : current CRC register value
//
// The register carries no reset: every load starts with a clear, so its
// contents before the first load are never observed.
// ---------------------------------------------------------------------------
module crc8_serial
  import cfg_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      crc_q <= CRC_INIT;
    end else if (en) begin
      crc_q <= crc8_step(crc_q, bit_in);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/config_loader.sv
// ---------------------------------------------------------------------------
// config_loader -- streams a host bitstream into an SRAM configuration scan
// chain, one byte at a time, MSB-first, for exactly CHAIN_LEN shift cycles.
//
// Parameter:
//   CHAIN_LEN : number of config bits in the scan chain (1..4096)
//
// Ports:
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   start     : one-cycle load request (honoured only in IDLE or DONE)
//   din       : bitstream byte from the host
//   din_valid : din holds a valid byte
//   din_ready : loader accepts din this cycle
//   scan_en   : chain shift enable
//   scan_in   : serial bit to the chain (0 whenever scan_en is 0)
//   busy      : load in progress
//   done      : load complete, held until the next accepted start
//   crc_err   : CRC mismatch on the completed load, valid while done=1
//
// Build option: define CFG_CRC_EN to shift a CRC-8 over the loaded bits and
// compare it with one trailing host byte. Without it crc_err is tied low.
//
// The host must hold the chain's write enable low while busy is 1; the
// chain gives write priority over scan_en and the loader does not arbitrate.
// ---------------------------------------------------------------------------
module config_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       scan_en,
  output logic       scan_in,
  output logic       busy,
  output logic       done,
  output logic       crc_err
);

  localparam int               CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;   // bits shifted so far in this load
  logic [2:0]       bit_idx;   // bit position inside the current byte
  logic [7:0]       sreg;
  logic             take;
  logic             load_go;
  logic             last_bit;

  assign take     = din_valid & din_ready;
  assign load_go  = ((state == IDLE) || (state == DONE)) && start;
  // The final byte may be partial: leaving SHIFT on the chain's last bit
  // discards any unshifted LSBs of that byte.
  assign last_bit = (state == SHIFT) && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      bit_idx <= '0;
    end else if (load_go) begin
      bit_cnt <= '0;
      bit_idx <= '0;
    end else if (state == SHIFT) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
      bit_idx <= bit_idx + 3'd1;   // wraps to 0 at each byte boundary
    end
  end

  // Data path: shift register needs no reset, scan_in is gated by scan_en.
  always_ff @(posedge clk) begin
    if ((state == WAIT_BYTE) && take) begin
      sreg <= din;
    end else if (state == SHIFT) begin
      sreg <= {sreg[6:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    scan_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        din_ready = 1'b1;
        busy      = 1'b1;
        if (din_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        scan_en = 1'b1;
        busy    = 1'b1;
        if (last_bit) begin
`ifdef CFG_CRC_EN
          state_nxt = CRC_BYTE;
`else
          state_nxt = DONE;
`endif
        end else if (bit_idx == 3'd7) begin
          state_nxt = WAIT_BYTE;
        end
      end
`ifdef CFG_CRC_EN
      CRC_BYTE: begin
        din_ready = 1'b1;
        busy      = 1'b1;
        if (din_valid) state_nxt = DONE;
      end
`endif
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = WAIT_BYTE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign scan_in = scan_en & sreg[7];

`ifdef CFG_CRC_EN
  logic [7:0] crc;
  logic       crc_err_q;

  crc8_serial u_crc (
    .clk    (clk),
    .clear  (load_go),
    .en     (scan_en),
    .bit_in (sreg[7]),
    .crc    (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_err_q <= 1'b0;
    end else if (load_go) begin
      crc_err_q <= 1'b0;
    end else if ((state == CRC_BYTE) && take) begin
      crc_err_q <= (din != crc);
    end
  end

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter: CHAIN_LEN, default 64, number of config bits in the downstream SRAM scan chain (legal range 1..4096).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  one-cycle request to begin loading a bitstream.
REQ-005 Port: din  input  8  bitstream byte from host.
REQ-006 Port: din_valid  input  1  din holds a valid byte.
REQ-007 Port: din_ready  output  1  loader accepts din this cycle.
REQ-008 Port: scan_en  output  1  shift enable to the chain.
REQ-009 Port: scan_in  output  1  serial bit to the chain.
REQ-010 Port: busy  output  1  load in progress.
REQ-011 Port: done  output  1  load complete; held until next accepted start.
REQ-012 Port: crc_err  output  1  CRC mismatch on the completed load; valid while done=1.

Function
REQ-013 States SHALL be IDLE, WAIT_BYTE, SHIFT, CRC_BYTE, DONE.
REQ-014 IDLE or DONE with start=1 -> WAIT_BYTE; clears done, crc_err, bit counter and CRC register.
REQ-015 start SHALL be ignored in WAIT_BYTE, SHIFT and CRC_BYTE.
REQ-016 din_ready SHALL be 1 only in WAIT_BYTE and CRC_BYTE; a transfer occurs when din_valid and din_ready are both 1.
REQ-017 A byte accepted in WAIT_BYTE SHALL load the shift register; SHIFT begins the next cycle.
REQ-018 In SHIFT, scan_en SHALL be 1 every cycle, with scan_in driven MSB-first from the shift register, one bit per cycle.
REQ-019 SHIFT SHALL last 8 cycles per byte, except for the final byte.
REQ-020 When CHAIN_LEN mod 8 = r and r != 0, only the r MSBs of the final byte SHALL be shifted; its remaining LSBs SHALL be discarded.
REQ-021 Exactly CHAIN_LEN scan_en cycles SHALL occur per load; the bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide.
REQ-022 After the last bit, SHIFT SHALL go to CRC_BYTE when CFG_CRC_EN is defined, else to DONE; otherwise it returns to WAIT_BYTE.
REQ-023 scan_en SHALL be 0 in every state other than SHIFT; scan_in SHALL be 0 when scan_en=0.
REQ-024 Because the chain's we has priority over scan_en, the host SHALL keep we low while busy=1; the loader does not arbitrate.
REQ-025 busy SHALL be 1 in WAIT_BYTE, SHIFT and CRC_BYTE; done SHALL be 1 only in DONE.
REQ-026 With the CHAIN_LEN bits shifted in order b0..bN-1, the first bit SHALL end at the chain's top bit (scan_out).

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and set scan_en, scan_in, din_ready, busy, done and crc_err to 0, including mid-load.
REQ-028 A load interrupted by reset leaves chain contents undefined; recovery is a new start.

Configuration
REQ-029 Macro CFG_CRC_EN defined: a CRC-8 (poly 0x07, init 0x00, MSB-first) SHALL be updated on each shifted bit.
REQ-030 With CFG_CRC_EN defined, one extra byte SHALL be accepted in CRC_BYTE and compared with the CRC; on mismatch crc_err=1, and the state then goes to DONE.
REQ-031 Macro CFG_CRC_EN undefined: there SHALL be no CRC logic and no CRC_BYTE state, and crc_err SHALL be tied to 0.

Structure
REQ-032 The state encoding enum and the CRC polynomial/init constants SHALL live in the shared package cfg_pkg.
REQ-033 The CRC-8 bit-serial update SHALL be a sub-module crc8_serial, instantiated only under CFG_CRC_EN.

Verification
REQ-034 CHAIN_LEN=16, start, bytes 0xA5, 0x3C (CRC off) -> 16 scan_en cycles, scan_in sequence 1010010100111100, chain = 16'hA53C, done=1.
REQ-035 CHAIN_LEN=12, bytes 0xA5, 0x3F -> exactly 12 scan_en cycles, chain = 12'hA53, low nibble of 0x3F unused.
REQ-036 CFG_CRC_EN, CHAIN_LEN=8, byte 0x01 then CRC 0x07 -> crc_err=0; repeat with CRC 0x06 -> crc_err=1.
REQ-037 din_valid toggled 0/1 randomly, start pulsed while busy -> no extra or missing shift cycles; start ignored.
REQ-038 rst_n asserted mid-SHIFT (bit 5 of 16) -> scan_en=0 same cycle, busy=0; a new start then completes a full 16-bit load.
